controller_input_conditioner: RTL and testbench
===============================================

Name: controller_input_conditioner

Overview:
Upstream stage of the NES controller read port. Takes the raw DE1-SoC push-buttons and slide switches and produces a clean byte of NES button state, one bit per button, that the controller read logic serialises to the CPU.
- Synchronises each input, debounces it, normalises polarity and applies D-pad lockout.
- Provides a strobe-latched snapshot using NES $4016 strobe semantics.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new level (10 ms at 50 MHz); legal values are 1 and above.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
KEY_ACTIVE_LOW, 1, when 1 BOARD_KEY is inverted so that pressed = 1.
DPAD_LOCKOUT, 1, when 1 opposing D-pad directions pressed together are both masked to 0.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
BOARD_SW  input  10  raw slide switches, asynchronous; only bits 3:0 are used
BOARD_KEY  input  4  raw push-buttons, asynchronous
latch  input  1  strobe from the CPU-side register ($4016 bit 0), synchronous to clk
buttons  output  8  live debounced button state, 1 = pressed
snapshot  output  8  button state captured by the strobe
changed  output  1  one-cycle pulse when buttons changes

Behaviour:
- Single clock domain is clk. Reset is asynchronous, active-high; all flops clear on reset assertion, with no dependence on clk.
- Bit mapping (buttons and snapshot): [0]=A=KEY[2], [1]=B=KEY[3], [2]=Select=KEY[0], [3]=Start=KEY[1], [4]=Up=SW[2], [5]=Down=SW[1], [6]=Left=SW[3], [7]=Right=SW[0].
- Polarity: KEY bits are inverted before the synchroniser when KEY_ACTIVE_LOW=1. SW bits are never inverted. After normalisation, 1 = pressed for every bit.
- Synchroniser: two flops per bit. Reset value is 0 (released).
- Debounce, per bit:
  - Holds a stable bit and a counter of width CNT_W.
  - If the synced value equals stable, the counter clears to 0.
  - If they differ and counter = DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - If they differ otherwise, the counter increments.
  - Result: a level is accepted after exactly DEBOUNCE_CYCLES consecutive mismatched cycles. Any shorter glitch restarts the count.
  - Counter never wraps. Reset sets stable and counter to 0.
- Pin-to-buttons latency: 2 + DEBOUNCE_CYCLES clk edges.
- Lockout:
  - buttons is combinational from the stable bits, adding no latency.
  - With DPAD_LOCKOUT=1: Up and Down both stable → buttons[4] and buttons[5] are 0. Left and Right both stable → buttons[6] and buttons[7] are 0.
  - Bits 0-3 are never masked.
  - With DPAD_LOCKOUT=0: buttons equals the stable bits.
- changed:
  - A registered copy prev of buttons is kept.
  - changed = 1 for the cycle after any edge at which buttons differs from prev, i.e. changed is registered from (buttons != prev).
  - Reset sets prev to 0 and changed to 0.
  - If lockout masks a new press so buttons does not change, there is no pulse.
- snapshot:
  - On each rising clk edge with latch=1, snapshot <= buttons. While latch stays high it reloads every cycle.
  - With latch=0, snapshot holds.
  - Reset sets snapshot to 0.
  - A button that becomes accepted on the same edge latch falls is not captured; snapshot takes the value buttons had before that edge.
- Reset mid-debounce discards partial counts. After release, a still-pressed input needs the full 2 + DEBOUNCE_CYCLES cycles to appear.
- BOARD_SW[9:4] are ignored. There are no combinational paths from raw pins to outputs.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1, DPAD_LOCKOUT=1.)
1. Reset, with KEY=4'hF and SW=0 → buttons=8'h00, snapshot=8'h00, changed=0. Drive KEY[2]=0 (A pressed) and hold → buttons=8'h01 exactly 6 edges later; changed=1 for one cycle on the following edge.
2. Glitch: drive KEY[3]=0 for 3 cycles, then back to 1 → buttons stays 8'h00 and changed never pulses. Then hold KEY[3]=0 for 10 cycles → buttons=8'h02.
3. Lockout: SW=4'b0110 (Up+Down) → buttons[5:4]=2'b00 and no changed pulse. Release SW[1] → after 6 edges buttons=8'h10 and changed pulses.
4. Strobe: with buttons=8'h09, hold latch=1 for 2 cycles then 0. Change inputs so buttons becomes 8'h80 → snapshot stays 8'h09 until the next latch=1 cycle, after which it reads 8'h80.
5. Reset mid-debounce: press KEY[0], assert reset after 3 cycles and deassert asynchronously mid-cycle → all outputs are 0 immediately. buttons=8'h04 arrives 6 edges after the first post-reset edge.
6. Simultaneous: all four KEYs pressed on the same cycle → buttons goes 8'h00→8'h0F on one edge with a single changed pulse.

Source files
------------

// File: rtl/controller_input_conditioner.sv
// Conditions the raw DE1-SoC push-buttons and slide switches into a clean NES button byte.
// Each input is normalised to 1 = pressed, synchronised, and debounced. Opposing D-pad
// directions are masked, and a strobe-latched snapshot follows $4016 semantics.
module controller_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter bit          DPAD_LOCKOUT    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] BOARD_SW,
    input  logic [3:0] BOARD_KEY,
    input  logic       latch,
    output logic [7:0] buttons,
    output logic [7:0] snapshot,
    output logic       changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       key_norm;
    logic [7:0]       raw;
    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       prev_q;
    logic             changed_q;
    logic [7:0]       snapshot_q;
    logic             unused_sw;

    // The upper switches are not mapped to any button.
    assign unused_sw = ^BOARD_SW[9:4];

    // Normalise polarity and place each pin at its NES button position.
    always_comb begin
        key_norm = KEY_ACTIVE_LOW ? ~BOARD_KEY : BOARD_KEY;
        raw = {BOARD_SW[0], BOARD_SW[3], BOARD_SW[1], BOARD_SW[2],
               key_norm[1], key_norm[0], key_norm[3], key_norm[2]};
    end

    // Two-flop synchroniser per bit; resets to released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a new level needs DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // D-pad lockout: opposing directions held together read as neither.
    always_comb begin
        buttons = stable_q;
        if (DPAD_LOCKOUT) begin
            if (stable_q[4] && stable_q[5]) begin
                buttons[5:4] = 2'b00;
            end
            if (stable_q[6] && stable_q[7]) begin
                buttons[7:6] = 2'b00;
            end
        end
    end

    // Change detect against the previous cycle's button byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= 8'h00;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= buttons;
            changed_q <= (buttons != prev_q);
        end
    end

    // Strobe capture: reloads every cycle while latch is high, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot_q <= 8'h00;
        end else if (latch) begin
            snapshot_q <= buttons;
        end
    end

    assign snapshot = snapshot_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_controller_input_conditioner.sv
// Self-checking bench: directed vector table, hand-written reset sequence, and random
// stimulus compared every cycle against a sliding-window reference model.
module tb_controller_input_conditioner;

    localparam int unsigned D = 4;

    logic       clk;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] key;
    logic       latch;
    logic [7:0] buttons;
    logic [7:0] snapshot;
    logic       changed;

    int n_cmp;
    int n_fail;

    // Reference model state
    logic [7:0] hist [0:7];
    logic [7:0] st_m;
    logic [7:0] prev_m;
    logic       chg_m;
    logic [7:0] snap_m;

    controller_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .KEY_ACTIVE_LOW (1'b1),
        .DPAD_LOCKOUT   (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .BOARD_SW (sw),
        .BOARD_KEY(key),
        .latch    (latch),
        .buttons  (buttons),
        .snapshot (snapshot),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] key;
        logic [9:0] sw;
        logic       latch;
        int         hold;
        logic [7:0] exp_btn;
        logic [7:0] exp_snap;
        logic       exp_chg;
    } vec_t;

    function automatic logic [7:0] norm(logic [3:0] k_raw, logic [9:0] s);
        logic [3:0] k;
        k = ~k_raw;
        return {s[0], s[3], s[1], s[2], k[1], k[0], k[3], k[2]};
    endfunction

    function automatic logic [7:0] lockout(logic [7:0] s);
        logic [7:0] m;
        m = s;
        if (s[4] && s[5]) m[5:4] = 2'b00;
        if (s[6] && s[7]) m[7:6] = 2'b00;
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) hist[i] = 8'h00;
        st_m   = 8'h00;
        prev_m = 8'h00;
        chg_m  = 1'b0;
        snap_m = 8'h00;
    endtask

    // A bit flips once the last D synchronised samples all disagree with its accepted level.
    task automatic model_edge();
        logic [7:0] btn_old;
        logic       all_diff;
        if (reset) begin
            model_clear();
            return;
        end
        btn_old = lockout(st_m);
        chg_m   = (btn_old != prev_m);
        prev_m  = btn_old;
        if (latch) snap_m = btn_old;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = norm(key, sw);
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                if (hist[j][b] == st_m[b]) all_diff = 1'b0;
            end
            if (all_diff) st_m[b] = ~st_m[b];
        end
    endtask

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check8({tag, "_buttons"}, buttons, lockout(st_m));
        check8({tag, "_snapshot"}, snapshot, snap_m);
        check8({tag, "_changed"}, {7'd0, changed}, {7'd0, chg_m});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model("model");
    endtask

    vec_t vecs[$];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        key    = 4'hF;
        sw     = 10'h000;
        latch  = 1'b0;
        model_clear();

        vecs = '{
            '{"reset_idle",    4'hF, 10'h000, 1'b0, 2,  8'h00, 8'h00, 1'b0},
            '{"a_before",      4'hB, 10'h000, 1'b0, 5,  8'h00, 8'h00, 1'b0},
            '{"a_accept",      4'hB, 10'h000, 1'b0, 1,  8'h01, 8'h00, 1'b0},
            '{"a_changed",     4'hB, 10'h000, 1'b0, 1,  8'h01, 8'h00, 1'b1},
            '{"a_pulse_end",   4'hB, 10'h000, 1'b0, 1,  8'h01, 8'h00, 1'b0},
            '{"a_release",     4'hF, 10'h000, 1'b0, 8,  8'h00, 8'h00, 1'b0},
            '{"glitch_b",      4'h7, 10'h000, 1'b0, 3,  8'h00, 8'h00, 1'b0},
            '{"glitch_after",  4'hF, 10'h000, 1'b0, 6,  8'h00, 8'h00, 1'b0},
            '{"b_held",        4'h7, 10'h000, 1'b0, 10, 8'h02, 8'h00, 1'b0},
            '{"b_release",     4'hF, 10'h000, 1'b0, 8,  8'h00, 8'h00, 1'b0},
            '{"lock_updown",   4'hF, 10'h006, 1'b0, 10, 8'h00, 8'h00, 1'b0},
            '{"down_rel_wait", 4'hF, 10'h004, 1'b0, 5,  8'h00, 8'h00, 1'b0},
            '{"up_appears",    4'hF, 10'h004, 1'b0, 1,  8'h10, 8'h00, 1'b0},
            '{"up_changed",    4'hF, 10'h004, 1'b0, 1,  8'h10, 8'h00, 1'b1},
            '{"a_start",       4'h9, 10'h000, 1'b0, 8,  8'h09, 8'h00, 1'b0},
            '{"strobe_hi",     4'h9, 10'h000, 1'b1, 2,  8'h09, 8'h09, 1'b0},
            '{"strobe_hold",   4'hF, 10'h001, 1'b0, 8,  8'h80, 8'h09, 1'b0},
            '{"strobe_again",  4'hF, 10'h001, 1'b1, 1,  8'h80, 8'h80, 1'b0},
            '{"strobe_low",    4'hF, 10'h001, 1'b0, 1,  8'h80, 8'h80, 1'b0},
            '{"all_release",   4'hF, 10'h000, 1'b0, 8,  8'h00, 8'h80, 1'b0},
            '{"all4_wait",     4'h0, 10'h000, 1'b0, 5,  8'h00, 8'h80, 1'b0},
            '{"all4_accept",   4'h0, 10'h000, 1'b0, 1,  8'h0F, 8'h80, 1'b0},
            '{"all4_changed",  4'h0, 10'h000, 1'b0, 1,  8'h0F, 8'h80, 1'b1},
            '{"all4_single",   4'h0, 10'h000, 1'b0, 1,  8'h0F, 8'h80, 1'b0},
            '{"keys_release",  4'hF, 10'h000, 1'b0, 8,  8'h00, 8'h80, 1'b0}
        };

        // Reset state
        repeat (3) tick();
        check8("reset_buttons", buttons, 8'h00);
        check8("reset_snapshot", snapshot, 8'h00);
        check8("reset_changed", {7'd0, changed}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[v]) begin
            key   = vecs[v].key;
            sw    = vecs[v].sw;
            latch = vecs[v].latch;
            repeat (vecs[v].hold) tick();
            check8({vecs[v].name, "_buttons"}, buttons, vecs[v].exp_btn);
            check8({vecs[v].name, "_snapshot"}, snapshot, vecs[v].exp_snap);
            check8({vecs[v].name, "_changed"}, {7'd0, changed}, {7'd0, vecs[v].exp_chg});
        end

        // Reset mid-debounce: a partial count must be discarded
        key = 4'hE;
        repeat (3) tick();
        #2 reset = 1'b1;
        model_clear();
        #1;
        check8("rst_async_buttons", buttons, 8'h00);
        check8("rst_async_snapshot", snapshot, 8'h00);
        check8("rst_async_changed", {7'd0, changed}, 8'h00);
        tick();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick();
        check8("rst_sel_edge5", buttons, 8'h00);
        tick();
        check8("rst_sel_edge6", buttons, 8'h04);
        tick();
        check8("rst_sel_changed", {7'd0, changed}, 8'h01);

        // Random stimulus against the model, with occasional async reset pulses
        for (int it = 0; it < 300; it++) begin
            key = 4'($urandom);
            sw  = 10'($urandom);
            repeat ($urandom_range(1, 8)) begin
                latch = ($urandom_range(0, 3) == 0);
                tick();
            end
            if ($urandom_range(0, 40) == 0) begin
                #2 reset = 1'b1;
                model_clear();
                #1;
                check_model("rand_rst");
                #2 reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
